// File: rtl/mem_io_pkg.sv
// Purpose: shared constants, byte type and address-decode helper for the memory/I-O responder.
// Latency: none; types, constants and a pure function only.
// Backpressure: not applicable.
package mem_io_pkg;

   localparam logic [1:0]  IO_REGION = 2'b11;
   localparam logic [17:0] ADDR_UART = 18'h30000;
   localparam logic [17:0] ADDR_CLK  = 18'h30004;
   localparam logic [17:0] RAM_LIMIT = 18'h20000;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_UNMAPPED,
      SEL_UART,
      SEL_CLK0,
      SEL_CLK1,
      SEL_CLK2,
      SEL_CLK3,
      SEL_OTHER
   } io_sel_t;

   // Only address bits 17:0 take part in the decode.
   function automatic io_sel_t decode_addr(input logic [17:0] a);
      io_sel_t sel;
      if (a[17:16] != IO_REGION) begin
         sel = (a < RAM_LIMIT) ? SEL_RAM : SEL_UNMAPPED;
      end else if (a == ADDR_UART) begin
         sel = SEL_UART;
      end else if (a[17:2] == ADDR_CLK[17:2]) begin
         case (a[1:0])
            2'd0:    sel = SEL_CLK0;
            2'd1:    sel = SEL_CLK1;
            2'd2:    sel = SEL_CLK2;
            default: sel = SEL_CLK3;
         endcase
      end else begin
         sel = SEL_OTHER;
      end
      return sel;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Purpose: synchronous byte FIFO (power-of-two DEPTH) with a free-entry count.
// Latency: a pushed byte is visible at head_o the cycle after the push edge.
// Backpressure: a push while full (judged before the same-cycle pop) is dropped; pop on empty is ignored.
//
// Ports: clk_in/rst_in (sync, active-high); push_i/push_dat_i write side;
//        pop_i read side; head_o oldest entry; empty_o; free_count_o unused entries.
module byte_fifo
   import mem_io_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       push_i,
   input  byte_t                      push_dat_i,
   input  logic                       pop_i,
   output byte_t                      head_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] free_count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   byte_t           mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok, pop_ok;

   // Fullness uses the pre-pop occupancy, so push+pop on a full FIFO drops the push.
   always_comb begin
      push_ok  = push_i && (count_q != CW'(DEPTH));
      pop_ok   = pop_i && (count_q != '0);
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; pointers alone define validity.
   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   assign head_o       = mem_q[rd_ptr_q];
   assign empty_o      = (count_q == '0);
   assign free_count_o = CW'(DEPTH) - count_q;

endmodule

// File: rtl/mem_io_responder.sv
// Purpose: byte-wide memory-bus responder: 128 KB RAM, UART TX/RX FIFOs, cycle counter, program stop.
// Latency: reads return on mem_din exactly one cycle after the address; writes commit at the sampling edge.
// Backpressure: io_buffer_full when free TX entries <= FULL_MARGIN; TX pushes while full are dropped and flagged.
//
// Ports: clk_in/rst_in (sync, active-high); mem_a/mem_wr/mem_dout bus request; mem_din read byte;
//        tx_data/tx_valid/tx_ready UART transmit; rx_data/rx_valid UART receive;
//        io_buffer_full, program_halt, tx_overflow status.
// Build option: define MEM_IO_RX_EN to build the receive FIFO; otherwise UART reads return 0x00.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int RAM_ADDR_W  = 17,
   parameter int TX_DEPTH    = 16,   // power of two, >= 4
   parameter int RX_DEPTH    = 16,   // power of two
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        program_halt,
   output logic        tx_overflow
);

   localparam int TXCW = $clog2(TX_DEPTH + 1);

   io_sel_t               sel;
   logic                  wr_en, rd_en;
   logic [RAM_ADDR_W-1:0] ram_idx;
   byte_t                 ram_mem [2**RAM_ADDR_W];
   byte_t                 ram_rd_q;
   logic                  unused_addr;

   logic [31:0] cnt_q, cnt_d;
   logic [31:0] cnt_latch_q, cnt_latch_d;
   byte_t       io_rd_q, io_rd_d, io_rd_byte;
   logic        ram_sel_q, ram_sel_d;
   logic        halt_q, halt_d;
   logic        ovf_q, ovf_d;
   logic        full_q, full_d;

   logic            tx_push, tx_push_ok, tx_pop, tx_empty;
   byte_t           tx_push_dat;
   logic [TXCW-1:0] tx_free, tx_free_nxt;
   byte_t           rx_byte;

   assign sel         = decode_addr(mem_a[17:0]);
   assign wr_en       = mem_wr && !halt_q;   // halt freezes every write, reads continue
   assign rd_en       = !mem_wr;
   assign ram_idx     = mem_a[RAM_ADDR_W-1:0];
   assign unused_addr = ^mem_a[31:18];

   // Single-port synchronous RAM; read enable keeps mem_din stable across writes.
   always_ff @(posedge clk_in) begin
      if (wr_en && sel == SEL_RAM) begin
         ram_mem[ram_idx] <= mem_dout;
      end
      if (rd_en && sel == SEL_RAM) begin
         ram_rd_q <= ram_mem[ram_idx];
      end
   end

   // TX: UART data writes (nonzero only) and the program-stop end marker share one push port.
   assign tx_push     = wr_en && ((sel == SEL_UART && mem_dout != 8'h00) || sel == SEL_CLK0);
   assign tx_push_dat = (sel == SEL_CLK0) ? 8'h00 : mem_dout;
   assign tx_valid    = !tx_empty;
   assign tx_pop      = tx_valid && tx_ready;
   assign tx_push_ok  = tx_push && (tx_free != '0);
   assign tx_free_nxt = tx_free - TXCW'(tx_push_ok) + TXCW'(tx_pop);

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_i       (tx_push),
      .push_dat_i   (tx_push_dat),
      .pop_i        (tx_pop),
      .head_o       (tx_data),
      .empty_o      (tx_empty),
      .free_count_o (tx_free)
   );

`ifdef MEM_IO_RX_EN
   logic                           rx_empty;
   byte_t                          rx_head;
   logic [$clog2(RX_DEPTH+1)-1:0]  unused_rx_free;

   byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_i       (rx_valid),
      .push_dat_i   (rx_data),
      .pop_i        (rd_en && sel == SEL_UART),
      .head_o       (rx_head),
      .empty_o      (rx_empty),
      .free_count_o (unused_rx_free)
   );

   // Empty FIFO reads 0x00 even if a byte is being pushed in the same cycle.
   assign rx_byte = rx_empty ? 8'h00 : rx_head;
`else
   logic                           unused_rx;
   logic [$clog2(RX_DEPTH+1)-1:0]  unused_rx_free;

   assign unused_rx      = ^{rx_data, rx_valid};
   assign unused_rx_free = '0;
   assign rx_byte        = 8'h00;
`endif

   always_comb begin
      io_rd_byte = 8'h00;
      case (sel)
         SEL_UART: io_rd_byte = rx_byte;
         SEL_CLK0: io_rd_byte = cnt_q[7:0];   // live value; the latch captures the same word
         SEL_CLK1: io_rd_byte = cnt_latch_q[15:8];
         SEL_CLK2: io_rd_byte = cnt_latch_q[23:16];
         SEL_CLK3: io_rd_byte = cnt_latch_q[31:24];
         default:  io_rd_byte = 8'h00;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q + 32'd1;
      cnt_latch_d = cnt_latch_q;
      io_rd_d     = io_rd_q;
      ram_sel_d   = ram_sel_q;
      if (rd_en) begin
         ram_sel_d = (sel == SEL_RAM);
         io_rd_d   = io_rd_byte;
         if (sel == SEL_CLK0) begin
            cnt_latch_d = cnt_q;
         end
      end
      halt_d = halt_q | (wr_en && sel == SEL_CLK0);
      ovf_d  = ovf_q | (tx_push && tx_free == '0);
      full_d = (tx_free_nxt <= TXCW'(FULL_MARGIN));
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_q       <= '0;
         cnt_latch_q <= '0;
         io_rd_q     <= '0;
         ram_sel_q   <= 1'b0;
         halt_q      <= 1'b0;
         ovf_q       <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         cnt_latch_q <= cnt_latch_d;
         io_rd_q     <= io_rd_d;
         ram_sel_q   <= ram_sel_d;
         halt_q      <= halt_d;
         ovf_q       <= ovf_d;
         full_q      <= full_d;
      end
   end

   // Both read sources are registers; the select is registered with them.
   assign mem_din        = ram_sel_q ? ram_rd_q : io_rd_q;
   assign io_buffer_full = full_q;
   assign program_halt   = halt_q;
   assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Purpose: self-checking bench for mem_io_responder (RAM, TX, back-pressure, counter, RX, halt, reset).
// Latency: inputs driven on the falling edge, outputs checked on the following falling edge.
// Backpressure: tx_ready is driven directly; TX bytes are collected just before each rising edge.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        program_halt;
   logic        tx_overflow;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  tx_seen [$];
   logic [31:0] mdl_cnt;

   typedef struct {
      logic [31:0] a;
      logic        wr;
      logic [7:0]  d;
      logic        chk;
      logic [7:0]  exp;
      string       name;
   } vec_t;

   vec_t vecs [16];

   always #5 clk_in = ~clk_in;

   mem_io_responder dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .program_halt   (program_halt),
      .tx_overflow    (tx_overflow)
   );

   // Reference cycle counter: cleared by reset, +1 on every other edge.
   always @(posedge clk_in) mdl_cnt <= rst_in ? 32'h0 : mdl_cnt + 32'h1;

   // Record every TX handshake shortly before the edge that completes it.
   always begin
      @(negedge clk_in);
      #4;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_seen.push_back(tx_data);
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
      @(negedge clk_in);
   endtask

   task automatic idle();
      bus(32'h0003_000C, 1'b0, 8'h00);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic wr, input logic [7:0] d,
                               input logic chk, input logic [7:0] exp, input string name);
      vec_t v;
      v.a = a; v.wr = wr; v.d = d; v.chk = chk; v.exp = exp; v.name = name;
      return v;
   endfunction

   function automatic logic [31:0] seen_at(input int i);
      return (i < tx_seen.size()) ? {24'h0, tx_seen[i]} : 32'hDEAD_BEEF;
   endfunction

   initial begin
      logic [7:0] e31, e32, e55;
      int guard;

`ifdef MEM_IO_RX_EN
      e31 = 8'h31; e32 = 8'h32; e55 = 8'h55;
`else
      e31 = 8'h00; e32 = 8'h00; e55 = 8'h00;
`endif

      vecs[0]  = mk(32'h0001_0000 - 32'h0000_FFF0, 1'b1, 8'hA5, 1'b0, 8'h00, "ram_wr");
      vecs[1]  = mk(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_rd_after_wr");
      vecs[2]  = mk(32'h0002_0004, 1'b0, 8'h00, 1'b1, 8'h00, "unmapped_rd");
      vecs[3]  = mk(32'h0000_0011, 1'b1, 8'h3C, 1'b1, 8'h00, "wr_hold_a");
      vecs[4]  = mk(32'h0000_0010, 1'b1, 8'h5A, 1'b0, 8'h00, "ram_overwrite_wr");
      vecs[5]  = mk(32'h0000_0011, 1'b0, 8'h00, 1'b1, 8'h3C, "ram_rd_b");
      vecs[6]  = mk(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h5A, "ram_overwrite");
      vecs[7]  = mk(32'h0000_0020, 1'b1, 8'h77, 1'b1, 8'h5A, "wr_hold_b");
      vecs[8]  = mk(32'h0001_FFFF, 1'b1, 8'hC3, 1'b0, 8'h00, "ram_top_wr");
      vecs[9]  = mk(32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'hC3, "ram_top");
      vecs[10] = mk(32'h0000_0000, 1'b1, 8'h11, 1'b0, 8'h00, "ram_zero_wr");
      vecs[11] = mk(32'h0002_0000, 1'b1, 8'h99, 1'b0, 8'h00, "unmapped_wr_cmd");
      vecs[12] = mk(32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h11, "unmapped_wr");
      vecs[13] = mk(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00, "io_other");
      vecs[14] = mk(32'h0003_0005, 1'b0, 8'h00, 1'b1, 8'h01, "cnt_latch_hold");
      vecs[15] = mk(32'h0003_FFFF, 1'b0, 8'h00, 1'b1, 8'h00, "io_other_top");

      // Reset state
      rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      mem_a = 32'h0003_000C; mem_wr = 1'b0; mem_dout = 8'h00;
      repeat (3) @(negedge clk_in);
      check("rst_mem_din", {24'h0, mem_din}, 32'h0);
      check("rst_io_full", {31'h0, io_buffer_full}, 32'h0);
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_halt", {31'h0, program_halt}, 32'h0);
      check("rst_tx_ovf", {31'h0, tx_overflow}, 32'h0);
      rst_in = 1'b0;

      // Counter: read 0x30004..7 starting at count 0x1FF
      guard = 0;
      while (mdl_cnt != 32'h1FF && guard < 2000) begin
         @(negedge clk_in);
         guard++;
      end
      if (guard >= 2000) check("cnt_wait_expired", mdl_cnt, 32'h1FF);
      bus(32'h0003_0004, 1'b0, 8'h00); check("cnt_b0", {24'h0, mem_din}, 32'hFF);
      bus(32'h0003_0005, 1'b0, 8'h00); check("cnt_b1", {24'h0, mem_din}, 32'h01);
      bus(32'h0003_0006, 1'b0, 8'h00); check("cnt_b2", {24'h0, mem_din}, 32'h00);
      bus(32'h0003_0007, 1'b0, 8'h00); check("cnt_b3", {24'h0, mem_din}, 32'h00);

      // Table-driven RAM / decode vectors
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus(vecs[i].a, vecs[i].wr, vecs[i].d);
         if (vecs[i].chk) check(vecs[i].name, {24'h0, mem_din}, {24'h0, vecs[i].exp});
      end

      // TX path: 'H' then a zero byte; only 'H' goes out
      tx_seen.delete();
      bus(32'h0003_0000, 1'b1, 8'h48);
      bus(32'h0003_0000, 1'b1, 8'h00);
      repeat (5) idle();
      check("tx_count", tx_seen.size(), 32'd1);
      check("tx_byte", seen_at(0), 32'h48);
      check("tx_idle_valid", {31'h0, tx_valid}, 32'h0);

      // Back-pressure and overflow, then push+pop on a full FIFO
      tx_ready = 1'b0;
      tx_seen.delete();
      for (int i = 0; i < 13; i++) bus(32'h0003_0000, 1'b1, 8'(8'h41 + i));
      check("full_after_13", {31'h0, io_buffer_full}, 32'h0);
      bus(32'h0003_0000, 1'b1, 8'h4E);
      check("full_after_14", {31'h0, io_buffer_full}, 32'h1);
      bus(32'h0003_0000, 1'b1, 8'h4F);
      bus(32'h0003_0000, 1'b1, 8'h50);
      check("ovf_after_16", {31'h0, tx_overflow}, 32'h0);
      bus(32'h0003_0000, 1'b1, 8'h51);
      check("ovf_after_17", {31'h0, tx_overflow}, 32'h1);
      tx_ready = 1'b1;
      bus(32'h0003_0000, 1'b1, 8'h60);
      repeat (25) idle();
      check("drain_count", tx_seen.size(), 32'd16);
      for (int i = 0; i < 16; i++) check("drain_byte", seen_at(i), 32'h41 + i);
      check("full_after_drain", {31'h0, io_buffer_full}, 32'h0);

      // RX: two pushes, three reads, then push+pop on empty
      rx_valid = 1'b1; rx_data = 8'h31; idle();
      rx_data = 8'h32; idle();
      rx_valid = 1'b0;
      bus(32'h0003_0000, 1'b0, 8'h00); check("rx_rd1", {24'h0, mem_din}, {24'h0, e31});
      bus(32'h0003_0000, 1'b0, 8'h00); check("rx_rd2", {24'h0, mem_din}, {24'h0, e32});
      bus(32'h0003_0000, 1'b0, 8'h00); check("rx_rd3_empty", {24'h0, mem_din}, 32'h00);
      rx_valid = 1'b1; rx_data = 8'h55;
      bus(32'h0003_0000, 1'b0, 8'h00); check("rx_push_pop_empty", {24'h0, mem_din}, 32'h00);
      rx_valid = 1'b0;
      bus(32'h0003_0000, 1'b0, 8'h00); check("rx_stored", {24'h0, mem_din}, {24'h0, e55});

      // Halt: end marker, then writes are frozen
      tx_seen.delete();
      bus(32'h0003_0004, 1'b1, 8'hAB);
      check("halt_set", {31'h0, program_halt}, 32'h1);
      bus(32'h0003_0000, 1'b1, 8'h5A);
      bus(32'h0000_0010, 1'b1, 8'hEE);
      bus(32'h0000_0010, 1'b0, 8'h00);
      check("ram_frozen", {24'h0, mem_din}, 32'h5A);
      repeat (4) idle();
      check("halt_tx_count", tx_seen.size(), 32'd1);
      check("halt_tx_byte", seen_at(0), 32'h00);

      // Reset mid-operation flushes FIFOs and the in-flight read
      rst_in = 1'b1; idle(); rst_in = 1'b0;
      check("rst2_halt", {31'h0, program_halt}, 32'h0);
      check("rst2_ovf", {31'h0, tx_overflow}, 32'h0);
      tx_ready = 1'b0;
      bus(32'h0003_0000, 1'b1, 8'h77);
      bus(32'h0003_0000, 1'b1, 8'h78);
      rx_valid = 1'b1; rx_data = 8'h66; idle(); rx_valid = 1'b0;
      bus(32'h0000_0010, 1'b0, 8'h00);
      check("pre_rst_ram", {24'h0, mem_din}, 32'h5A);
      check("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
      rst_in = 1'b1;
      bus(32'h0000_0010, 1'b0, 8'h00);
      check("rst3_inflight", {24'h0, mem_din}, 32'h00);
      check("rst3_tx_flush", {31'h0, tx_valid}, 32'h0);
      rst_in = 1'b0;
      bus(32'h0003_0000, 1'b0, 8'h00);
      check("rst3_rx_flush", {24'h0, mem_din}, 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Responder end of the CPU's byte-wide memory bus: it accepts the address, the write strobe and the write byte driven by `cpu`, and answers with a registered read byte one cycle later. It holds the 128 KB main RAM and decodes the I/O window at `mem_a[17:16]==2'b11`: UART transmit and receive, the cycle counter, and program stop. It drives `io_buffer_full` back to the CPU and replaces the behavioural RAM and host-interface glue in the simulation and FPGA top levels.

## Interface
- `RAM_ADDR_W`, 17: RAM address width; RAM holds 2^17 bytes.
- `TX_DEPTH`, 16: transmit FIFO entries; must be a power of two and at least 4.
- `RX_DEPTH`, 16: receive FIFO entries; must be a power of two.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when the number of free TX entries is at most this value.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset; synchronous, active-high.
- `mem_a` in 32: byte address from the CPU; only bits 17:0 are decoded.
- `mem_wr` in 1: 1 = write, 0 = read.
- `mem_dout` in 8: write byte from the CPU.
- `mem_din` out 8: read byte returned to the CPU.
- `io_buffer_full` out 1: UART transmit back-pressure to the CPU.
- `tx_data` out 8: byte offered to the UART transmitter.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the UART transmitter accepts the byte.
- `rx_data` in 8: byte received from the UART.
- `rx_valid` in 1: push `rx_data` into the receive FIFO.
- `program_halt` out 1: sticky flag; set by the program-stop write.
- `tx_overflow` out 1: sticky flag; set when a TX byte is dropped.

## Operation
Address decode. Call the upper bits `mem_a[17:16]` the region.
- Region is not `11`, and the address is below 0x20000: RAM.
- Region is not `11`, and the address is at or above 0x20000: unmapped. Writes are ignored and reads return 0x00.
- 0x30000 read: pop one byte from the RX FIFO. If the FIFO is empty, return 0x00 and pop nothing.
- 0x30000 write:
  - A nonzero byte is pushed to the TX FIFO.
  - A 0x00 byte is ignored.
- 0x30004 read:
  - Capture the 32-bit cycle counter into `cnt_latch`.
  - Return byte 0 of the counter value as it stands in that cycle.
- 0x30005–0x30007 read: return bytes 1–3 of `cnt_latch`, with no side effect.
- 0x30004 write:
  - Push 0x00 into the TX FIFO as the end marker.
  - Set `program_halt`.
  - After this, all further writes to RAM and I/O are ignored. Reads still work.
- Any other I/O address: read returns 0x00, write is ignored.

Cycle counter:
- 32 bits, cleared by reset, increments every cycle, wraps from 0xFFFFFFFF to 0.

TX FIFO:
- Pops when `tx_valid && tx_ready`.
- A push while full is dropped and sets `tx_overflow`.
- "Full" is judged on the occupancy before the same cycle's pop. A push and a pop in the same cycle on a full FIFO drops the push.

RX FIFO:
- A push (`rx_valid`) while full is dropped silently.
- A push and a pop in the same cycle on an empty FIFO: the pop returns 0x00, and the pushed byte is stored.

## Timing
- Read latency is exactly 1 cycle. `mem_din` is registered and takes the value for the address presented in the previous cycle.
- When `mem_wr` is high, `mem_din` holds its previous value.
- Writes commit at the clock edge that samples them; there is no wait state.
- A read of address A in the cycle right after a write to A returns the new byte (RAM is write-first on consecutive cycles).
- `io_buffer_full` is registered and computed from the post-update occupancy: it is 1 iff free entries ≤ `FULL_MARGIN`.
- `tx_valid` is combinational from "TX FIFO not empty"; `tx_data` is the head entry.
- Reset values:
  - `mem_din`, `io_buffer_full`, `tx_valid`, `program_halt`, `tx_overflow`: 0.
  - Counter and `cnt_latch`: 0.
  - Both FIFOs empty.
  - RAM contents are not reset.
- Reset asserted mid-operation flushes both FIFOs in the same edge. Any in-flight read is lost.

## Configuration
- `MEM_IO_RX_EN` defined: RX FIFO present; 0x30000 reads behave as described above.
- `MEM_IO_RX_EN` undefined:
  - The RX FIFO is not built, and `rx_data`/`rx_valid` are ignored.
  - 0x30000 reads return 0x00.
  - Port list is unchanged.

## Structure
- Package `mem_io_pkg` holds the constants:
  - `IO_REGION` (2'b11), `ADDR_UART` (0x30000), `ADDR_CLK` (0x30004), `RAM_LIMIT` (0x20000).
  - The byte type and the `io_sel_t` decode enum (RAM, UNMAPPED, UART, CLK0..CLK3, OTHER).
- One sub-module, `byte_fifo`, parameterised by depth and exposing a `free_count` output. It is instantiated for TX, and for RX under the macro.
- RAM is inferred inside the top level as a single-port synchronous array.

## Test plan
- RAM path:
  - Stimulus: write 0xA5 to 0x00010, then read 0x00010 in the next cycle.
  - Expect: `mem_din`=0xA5 one cycle after the read cycle.
  - Also: a read of 0x20004 returns 0x00.
- TX path:
  - Stimulus: write 'H' then 0x00 to 0x30000, with `tx_ready`=1.
  - Expect: exactly one byte 0x48 on `tx_data`/`tx_valid`.
- Back-pressure:
  - Stimulus: hold `tx_ready`=0 and write 14 nonzero bytes (depth 16, margin 2).
  - Expect: `io_buffer_full`=1 after the 14th.
  - Then write 3 more bytes. Expect: 2 accepted, the 3rd dropped, `tx_overflow`=1.
- Counter:
  - Stimulus: read 0x30004–0x30007 on consecutive cycles starting at counter value 0x000001FF.
  - Expect: 0xFF, 0x01, 0x00, 0x00.
- RX (macro defined):
  - Stimulus: push 0x31 and 0x32 via `rx_valid`, then read 0x30000 three times.
  - Expect: 0x31, 0x32, 0x00.
- Halt:
  - Stimulus: write to 0x30004.
  - Expect: `program_halt`=1 and 0x00 appears on `tx_data`.
  - A subsequent RAM write to 0x00010 leaves the old byte in place on read-back.
